// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: datapath widths, fetch state encoding
// and the address the fetch unit starts from after reset.
package cpu_pkg;

  localparam int ADDR_W  = 16;
  localparam int INSTR_W = 16;

  typedef logic [ADDR_W-1:0]  addr_t;
  typedef logic [INSTR_W-1:0] instr_t;

  localparam addr_t RESET_ADDR = 16'd0;

  typedef enum logic [1:0] {
    ISSUE,
    WAIT,
    HOLD
  } fetch_state_e;

endpackage

// File: rtl/instr_fetch.sv
// Single-outstanding instruction fetch unit between the PC and decode.
// Define INSTR_FETCH_STATS_EN to add fetch_count/flush_count statistics outputs.
module instr_fetch
  import cpu_pkg::*;
#(
  parameter int                ADDR_W     = cpu_pkg::ADDR_W,
  parameter int                INSTR_W    = cpu_pkg::INSTR_W,
  parameter logic [ADDR_W-1:0] RESET_ADDR = cpu_pkg::RESET_ADDR
) (
  input  logic               clk,
  input  logic               reset,
  output logic [ADDR_W-1:0]  pc_addr,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               imem_rvalid,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_addr,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc
`ifdef INSTR_FETCH_STATS_EN
  ,
  output logic [31:0]        fetch_count,
  output logic [15:0]        flush_count
`endif
);

  fetch_state_e       state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic               kill_q, kill_d;
  logic               instrValid_q, instrValid_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0]  instrPc_q, instrPc_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ISSUE;
      pc_q         <= RESET_ADDR;
      kill_q       <= 1'b0;
      instrValid_q <= 1'b0;
      instr_q      <= '0;
      instrPc_q    <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      kill_q       <= kill_d;
      instrValid_q <= instrValid_d;
      instr_q      <= instr_d;
      instrPc_q    <= instrPc_d;
    end
  end

  // A redirect wins in every state; a request still in flight is marked
  // killed so its eventual response is dropped instead of delivered.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    kill_d       = kill_q;
    instrValid_d = instrValid_q;
    instr_d      = instr_q;
    instrPc_d    = instrPc_q;
    if (redirect_valid) begin
      pc_d = redirect_addr;
      unique case (state_q)
        ISSUE: state_d = ISSUE;
        WAIT: begin
          if (imem_rvalid) begin
            kill_d  = 1'b0;
            state_d = ISSUE;
          end else begin
            kill_d = 1'b1;
          end
        end
        HOLD: begin
          instrValid_d = 1'b0;
          state_d      = ISSUE;
        end
        default: state_d = ISSUE;
      endcase
    end else begin
      unique case (state_q)
        ISSUE: state_d = WAIT;
        WAIT: begin
          if (imem_rvalid) begin
            if (kill_q) begin
              kill_d  = 1'b0;
              state_d = ISSUE;
            end else begin
              instr_d      = imem_rdata;
              instrPc_d    = pc_q;
              instrValid_d = 1'b1;
              pc_d         = pc_q + ADDR_W'(1);
              state_d      = HOLD;
            end
          end
        end
        HOLD: begin
          if (instr_ready) begin
            instrValid_d = 1'b0;
            state_d      = ISSUE;
          end
        end
        default: state_d = ISSUE;
      endcase
    end
  end

  assign imem_req    = (state_q == ISSUE) && !redirect_valid && !reset;
  assign imem_addr   = imem_req ? pc_q : '0;
  assign pc_addr     = pc_q;
  assign instr_valid = instrValid_q;
  assign instr       = instr_q;
  assign instr_pc    = instrPc_q;

`ifdef INSTR_FETCH_STATS_EN
  logic [31:0] fetchCount_q;
  logic [15:0] flushCount_q;

  // A handshake coinciding with a redirect is a flush, not a delivery.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetchCount_q <= '0;
      flushCount_q <= '0;
    end else begin
      if (instrValid_q && instr_ready && !redirect_valid)
        fetchCount_q <= fetchCount_q + 32'd1;
      if (redirect_valid && (state_q != ISSUE))
        flushCount_q <= flushCount_q + 16'd1;
    end
  end

  assign fetch_count = fetchCount_q;
  assign flush_count = flushCount_q;
`endif

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
Instruction fetch unit consuming the program-counter address stream. It issues one read at a time to instruction memory, returns fetched instructions to decode over a valid/ready handshake, and sends the next sequential address back toward the PC. Sits between the pc block and decode; redirects (branch/jump) arrive from execute.

Parameters:
ADDR_W, 16, address width (word-addressed instruction memory)
INSTR_W, 16, instruction width
RESET_ADDR, 16'd0, first fetch address after reset

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
pc_addr  out  ADDR_W  address currently being fetched (feeds pc input_address)
imem_req  out  1  memory read request, one cycle pulse per access
imem_addr  out  ADDR_W  memory read address, valid when imem_req=1
imem_rdata  in  INSTR_W  memory read data
imem_rvalid  in  1  read data valid; 1..N cycles after imem_req
redirect_valid  in  1  branch/jump taken this cycle
redirect_addr  in  ADDR_W  target address
instr_valid  out  1  instruction available to decode
instr_ready  in  1  decode accepts instruction
instr  out  INSTR_W  fetched instruction
instr_pc  out  ADDR_W  address of instr

Behaviour:
- Reset (clk edge with reset=1): state=ISSUE, pc_addr=RESET_ADDR, imem_req=0, imem_addr=0, instr_valid=0, instr=0, instr_pc=0, kill=0. Reset overrides all other inputs, including mid-access; a late imem_rvalid after reset is ignored unless a request is outstanding.
- States: ISSUE, WAIT, HOLD.
- ISSUE: drive imem_req=1, imem_addr=pc_addr for exactly one cycle; go WAIT.
- WAIT: on imem_rvalid: if kill=1 discard data, clear kill, go ISSUE; else latch instr=imem_rdata, instr_pc=pc_addr, instr_valid=1, pc_addr=pc_addr+1, go HOLD.
- HOLD: instr, instr_pc stable while instr_valid=1 and instr_ready=0. On instr_ready=1: instr_valid=0 next cycle, go ISSUE. Throughput: one instruction per 3 cycles with 1-cycle memory.
- Increment is modulo 2^ADDR_W: 16'hFFFF -> 16'h0000, no flag.
- Redirect (highest priority after reset), any state:
  - ISSUE: pc_addr=redirect_addr; no request issued that cycle; stay ISSUE.
  - WAIT without imem_rvalid same cycle: pc_addr=redirect_addr, kill=1; stay WAIT.
  - WAIT with imem_rvalid same cycle: data discarded, pc_addr=redirect_addr, go ISSUE.
  - HOLD: instr_valid=0 next cycle (held instruction flushed even if instr_ready=1 same cycle), pc_addr=redirect_addr, go ISSUE.
- Only one outstanding memory request ever; imem_rvalid outside WAIT is ignored.
- pc_addr is registered; an address of 0 is legal.

Optional Feature:
INSTR_FETCH_STATS_EN: when defined, adds output fetch_count (32 bits), reset to 0, incremented on every accepted handshake (instr_valid & instr_ready, not flushed), wrapping at 2^32; plus output flush_count (16 bits) counting redirects that discarded a request or held instruction. When undefined, ports and counters are absent; all other behaviour identical.

Decomposition:
- Shared package cpu_pkg: ADDR_W/INSTR_W constants, addr_t/instr_t typedefs, fetch state enum {ISSUE, WAIT, HOLD}, RESET_ADDR constant.
- No sub-module required; the optional counters are simple enough to stay inline.

Test Plan:
- Reset then memory returning rdata=addr+16'h1000 at 1-cycle latency, instr_ready=1 -> instr/instr_pc pairs (0x1000,0), (0x1001,1), (0x1002,2); instr_valid 1 cycle every 3.
- instr_ready=0 for 5 cycles in HOLD -> instr, instr_pc unchanged, no imem_req; after ready, next fetch at pc+1.
- Redirect to 0x0040 in WAIT, memory responds 3 cycles later -> stale data dropped, next imem_addr=0x0040, first delivered instr_pc=0x0040.
- Redirect to 0x0200 in HOLD with instr_ready=1 same cycle -> instruction not consumed, next instr_pc=0x0200 (and fetch_count unchanged when INSTR_FETCH_STATS_EN).
- Redirect to 0xFFFF, two fetches -> instr_pc 0xFFFF then 0x0000.
- Reset asserted during WAIT, rvalid arrives afterward -> instr_valid stays 0, next imem_addr=RESET_ADDR.
